// File: rtl/clock_divisor_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Imported by the divider top level and its per-channel sub-module.
package clock_divisor_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int MIN_DIV   = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] cnt;
        logic [CNT_W_DEF-1:0] d_act;
        logic [CNT_W_DEF-1:0] d_shd;
        logic                 pending;
    } ch_state_t;

endpackage

// File: rtl/clock_divisor_multi_div_channel.sv
// One divider channel: counter, active/shadow divide values and registered
// clock/tick outputs. Shadow values only become active on a period boundary.
module div_channel
    import clock_divisor_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(100)
) (
    input  logic             clock1M,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] d_act;
    logic [CNT_W-1:0] d_shd;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;
    logic             xfer;

    always_comb begin
        wrap    = (cnt == d_act - CNT_W'(1));
        xfer    = !en || sync || wrap;
        cnt_nxt = cnt + CNT_W'(1);
        if (sync || wrap) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            cnt     <= DIV_INIT - CNT_W'(1);
            d_act   <= DIV_INIT;
            d_shd   <= DIV_INIT;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else begin
            // Transfer uses the shadow as it was before any write on this edge.
            if (xfer) begin
                d_act <= d_shd;
            end
            if (wr) begin
                d_shd   <= wr_div;
                pending <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end
            if (!en) begin
                // Park on the last count of the incoming divide so the first
                // enabled edge always wraps to zero.
                cnt     <= d_shd - CNT_W'(1);
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                cnt     <= cnt_nxt;
                clk_out <= (cnt_nxt < (d_act >> 1));
                tick    <= (cnt_nxt == '0);
            end
        end
    end

endmodule

// File: rtl/clock_divisor_multi.sv
// Multi-channel programmable clock divider: configuration write decode,
// error reporting and N_CH independent divider channels.
module clock_divisor_multi
    import clock_divisor_pkg::*;
#(
    parameter int                          N_CH    = 2,
    parameter int                          CNT_W   = CNT_W_DEF,
    parameter logic [N_CH-1:0][CNT_W-1:0]  DIV_RST = {16'd10, 16'd100},
    localparam int                         CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock1M,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  cfg_pending,
    output logic             cfg_err
);

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic wr_ok;

    // Extra MSB lets the channel range check work when N_CH is a power of two.
    always_comb begin
        wr_ok = cfg_we && (cfg_div >= CNT_W'(MIN_DIV)) && ({1'b0, cfg_ch} < N_CH_L);
    end

    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !wr_ok;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic wr_sel;

        always_comb begin
            wr_sel = wr_ok && (cfg_ch == CH_W'(gi));
        end

        div_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_RST[gi])
        ) u_ch (
            .clock1M (clock1M),
            .reset   (reset),
            .en      (en[gi]),
            .sync    (sync),
            .wr      (wr_sel),
            .wr_div  (cfg_div),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi]),
            .pending (cfg_pending[gi])
        );
    end

endmodule

// File: tb/tb_clock_divisor_multi.sv
// Scoreboard bench for clock_divisor_multi: directed scenarios followed by
// random traffic, checked against a period-position reference model.
module tb_clock_divisor_multi;

    localparam int N  = 3;
    localparam int CW = 16;
    localparam logic [N-1:0][CW-1:0] DIVS = {16'd13, 16'd10, 16'd100};

    typedef struct packed {
        logic [N-1:0] clk;
        logic [N-1:0] tck;
        logic [N-1:0] pnd;
        logic         err;
    } obs_t;

    logic          clock1M = 1'b0;
    logic          reset   = 1'b1;
    logic [N-1:0]  en      = '0;
    logic          sync    = 1'b0;
    logic          cfg_we  = 1'b0;
    logic [1:0]    cfg_ch  = '0;
    logic [CW-1:0] cfg_div = '0;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  tick;
    logic [N-1:0]  cfg_pending;
    logic          cfg_err;

    int   total = 0;
    int   bad   = 0;
    bit   started = 0;
    obs_t exp_q[$];
    obs_t last;

    // Reference model: position inside the current period plus divide values.
    int pos [N];
    int da  [N];
    int ds  [N];
    bit pend[N];

    clock_divisor_multi #(
        .N_CH    (N),
        .CNT_W   (CW),
        .DIV_RST (DIVS)
    ) dut (
        .clock1M     (clock1M),
        .reset       (reset),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    always #5 clock1M = ~clock1M;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            da[c]   = int'(DIVS[c]);
            ds[c]   = int'(DIVS[c]);
            pos[c]  = da[c] - 1;
            pend[c] = 1'b0;
        end
        last = '0;
    endtask

    task automatic model_step(input logic [N-1:0] e, input logic s, input logic we,
                              input int ch, input int dv, output obs_t o);
        bit err;
        err = we && (dv < 2 || ch >= N);
        o = '0;
        o.err = err;
        for (int c = 0; c < N; c++) begin
            bit wr;
            bit xf;
            wr = we && !err && (ch == c);
            xf = 1'b0;
            if (!e[c]) begin
                xf = 1'b1;
                da[c] = ds[c];
                pos[c] = da[c] - 1;
            end else if (s) begin
                xf = 1'b1;
                da[c] = ds[c];
                pos[c] = 0;
            end else begin
                pos[c] = pos[c] + 1;
                if (pos[c] == da[c]) begin
                    xf = 1'b1;
                    da[c] = ds[c];
                    pos[c] = 0;
                end
            end
            if (e[c]) begin
                o.clk[c] = (pos[c] < da[c] / 2);
                o.tck[c] = (pos[c] == 0);
            end
            if (wr) begin
                ds[c] = dv;
                pend[c] = 1'b1;
            end else if (xf) begin
                pend[c] = 1'b0;
            end
            o.pnd[c] = pend[c];
        end
    endtask

    task automatic cyc(input logic [N-1:0] e, input logic s, input logic we,
                       input int ch, input int dv);
        obs_t o;
        reset   = 1'b0;
        en      = e;
        sync    = s;
        cfg_we  = we;
        cfg_ch  = 2'(ch);
        cfg_div = CW'(dv);
        model_step(e, s, we, ch, dv, o);
        last = o;
        exp_q.push_back(o);
        started = 1'b1;
        @(negedge clock1M);
    endtask

    task automatic rst_cyc();
        reset   = 1'b1;
        en      = '0;
        sync    = 1'b0;
        cfg_we  = 1'b0;
        model_reset();
        exp_q.push_back('0);
        started = 1'b1;
        @(negedge clock1M);
    endtask

    // Asserts reset between clock edges and checks that outputs clear at once.
    task automatic async_reset_check();
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({clk_out, tick, cfg_pending, cfg_err} !== '0) begin
            bad++;
            $display("FAIL async_reset: got clk=%b tick=%b pend=%b err=%b, want all zero",
                     clk_out, tick, cfg_pending, cfg_err);
        end
        en     = '0;
        sync   = 1'b0;
        cfg_we = 1'b0;
        model_reset();
        exp_q.push_back('0);
        @(negedge clock1M);
    endtask

    task automatic run(input int n, input logic [N-1:0] e);
        for (int i = 0; i < n; i++) cyc(e, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clock1M);
            #1;
            if (exp_q.size() == 0) begin
                if (started) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: got no expectation at t=%0t, want one", $time);
                end
            end else begin
                e = exp_q.pop_front();
                a = {clk_out, tick, cfg_pending, cfg_err};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t: got clk=%b tick=%b pend=%b err=%b, want clk=%b tick=%b pend=%b err=%b",
                             $time, a.clk, a.tck, a.pnd, a.err, e.clk, e.tck, e.pnd, e.err);
                end
            end
        end
    end

    initial begin : driver
        bit found;
        model_reset();
        for (int i = 0; i < 3; i++) rst_cyc();

        run(210, 3'b111);
        run(4, 3'b111);
        cyc(3'b111, 1'b0, 1'b1, 1, 7);
        run(40, 3'b111);

        cyc(3'b111, 1'b0, 1'b1, 0, 1);
        cyc(3'b111, 1'b0, 1'b1, 3, 5);
        run(20, 3'b111);

        run(7, 3'b111);
        cyc(3'b111, 1'b1, 1'b0, 0, 0);
        run(120, 3'b111);

        cyc(3'b110, 1'b0, 1'b0, 0, 0);
        run(5, 3'b110);
        run(30, 3'b111);

        cyc(3'b111, 1'b1, 1'b1, 1, 4);
        run(30, 3'b111);
        cyc(3'b111, 1'b0, 1'b1, 2, 9);
        cyc(3'b111, 1'b0, 1'b1, 2, 5);
        run(30, 3'b111);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (last.clk[1]) found = 1'b1;
            else cyc(3'b111, 1'b0, 1'b0, 0, 0);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_high: got clk_out[1] never high within 20 cycles, want high");
        end
        async_reset_check();
        rst_cyc();
        run(120, 3'b111);

        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] e;
            logic         s;
            logic         we;
            int           dv;
            e  = ($urandom % 8 == 0) ? N'($urandom) : 3'b111;
            s  = ($urandom % 60 == 0);
            we = ($urandom % 6 == 0);
            dv = ($urandom % 8 == 0) ? int'($urandom % 2) : int'(2 + $urandom % 23);
            if ($urandom % 700 == 0) begin
                async_reset_check();
                rst_cyc();
            end else begin
                cyc(e, s, we, int'($urandom % 4), dv);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock1M);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_divisor_multi.md
CLOCK_DIVISOR_MULTI -- requirements
Module: clock_divisor_multi

Interface
REQ-001 Parameter N_CH, default 2: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 16: width of divide values and counters.
REQ-003 Parameter DIV_RST, default {ch1=10, ch0=100}: per-channel divide value loaded at reset. Each entry SHALL be at least 2.
REQ-004 clock1M  input  1  sole clock, 1 MHz nominal; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  N_CH  per-channel run enable.
REQ-007 sync  input  1  restarts all enabled channels in phase.
REQ-008 cfg_we  input  1  single-cycle configuration write strobe.
REQ-009 cfg_ch  input  max(1,$clog2(N_CH))  target channel of the write.
REQ-010 cfg_div  input  CNT_W  new divide value D.
REQ-011 clk_out  output  N_CH  divided clocks, registered.
REQ-012 tick  output  N_CH  one-cycle pulse, coincident with each clk_out rising edge.
REQ-013 cfg_pending  output  N_CH  shadow value written but not yet active.
REQ-014 cfg_err  output  1  one-cycle pulse on a rejected write.

Function
REQ-015 Per channel state: cnt (CNT_W), d_act (active D), d_shd (shadow D).
REQ-016 Enabled, no sync: cnt_next = (cnt == d_act-1) ? 0 : cnt+1.
REQ-017 Registered outputs follow cnt_next: clk_out <= (cnt_next < d_act/2, floor); tick <= (cnt_next == 0).
- Period = D cycles; high for floor(D/2) cycles; D=2 gives 1 high, 1 low; D=7 gives 3 high, 4 low.
REQ-018 Disabled channel: cnt <= d_act-1; clk_out <= 0; tick <= 0; d_act <= d_shd.
REQ-019 First enabled edge after disable wraps cnt to 0, so tick=1 and clk_out=1 one cycle after en is sampled high.
REQ-020 Accepted write: d_shd[cfg_ch] <= cfg_div; cfg_pending set.
REQ-021 Shadow transfer only at a wrap (cnt == d_act-1, enabled), on sync, or while disabled; cfg_pending clears at that same edge.
- Result: no truncated or glitched period.
REQ-022 Write rejected when cfg_div < 2 or cfg_ch >= N_CH: no state change; cfg_err=1 for exactly the next cycle.
REQ-023 sync=1: every enabled channel takes d_act <= d_shd, cnt <= 0, tick <= 1, clk_out <= 1.
- Disabled channels are unaffected by sync.
REQ-024 Write and sync on the same edge: write lands in d_shd; sync transfers the previous shadow; the new value applies at the next wrap.
REQ-025 Write and wrap on the same edge for the same channel: wrap transfers the previous shadow; the new value waits for the following wrap.
REQ-026 Back-to-back writes to one channel before a wrap: last write wins.
REQ-027 Counter arithmetic SHALL be unsigned, CNT_W bits, with no overflow for any D <= 2^CNT_W-1.

Reset
REQ-028 reset=1 asynchronously forces:
- cnt <= DIV_RST[i]-1; d_act and d_shd <= DIV_RST[i].
- clk_out, tick, cfg_pending, cfg_err <= 0.
REQ-029 Reset asserted mid-period aborts immediately; after release the channels behave as in REQ-019.

Structure
REQ-030 Package clock_divisor_pkg SHALL hold:
- CNT_W default.
- MIN_DIV = 2.
- Per-channel state struct typedef {cnt, d_act, d_shd, pending}.
REQ-031 Sub-module div_channel SHALL implement one channel (REQ-015..021, 023, 025) and be instantiated N_CH times by generate.
- Write decode and cfg_err stay in the top level.

Verification
REQ-032 Release reset, en=2'b11: clk_out[1] period 10 (5 high); clk_out[0] period 100 (50 high); one tick per rise; first ticks 1 cycle after release.
REQ-033 Write ch1 D=7 mid-period:
- Current 10-cycle period completes, then 3 high / 4 low.
- cfg_pending[1] high from the write until that wrap.
REQ-034 Write D=1, then cfg_ch=3 (N_CH=2): cfg_err pulses 1 cycle each; periods unchanged; cfg_pending unchanged.
REQ-035 Pulse sync at an arbitrary cycle: next cycle tick=2'b11 and clk_out=2'b11; afterwards tick[0] coincides with every 10th tick[1].
REQ-036 Drop en[0]: clk_out[0]=0 next cycle. Re-raise it: tick[0]=1 one cycle after.
REQ-037 Assert reset mid-high phase: outputs 0 without waiting for a clock edge; sequence of REQ-032 repeats after release.
